ram_d_arb: RTL
==============

// Module: ram_d_arb
// PURPOSE
//  Shares one ram_d (dual-port BRAM: port A read/write, port B read-only, 1-cycle read latency,
//  common enable) between two port-A requesters (e.g. aggregation writer, path-cost reader) and
//  one dedicated port-B reader. Round-robin arbitration on port A, read-valid return pipeline,
//  enable gating when idle. Sits between the SGBM cost/aggregation stages and the line-store RAM.
// PARAMETERS
//  addr_bits  8   RAM address width; depth = 1<<addr_bits
//  data_bits  16  RAM word width
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous active-low reset
//  r0_req     in   1          requester 0 access request; held until r0_gnt
//  r0_we      in   1          1 = write, 0 = read; valid with r0_req
//  r0_addr    in   addr_bits  requester 0 address
//  r0_wdata   in   data_bits  requester 0 write data
//  r0_gnt     out  1          combinational grant; access happens this cycle
//  r0_rvalid  out  1          read data valid (one cycle after granted read)
//  r0_rdata   out  data_bits  read data; 0 when r0_rvalid=0
//  r1_*       same set as r0_* for requester 1
//  b_req      in   1          port-B read request (never stalled)
//  b_addr     in   addr_bits  port-B read address
//  b_rvalid   out  1          port-B data valid one cycle after b_req
//  b_rdata    out  data_bits  port-B read data; 0 when b_rvalid=0
// BEHAVIOUR
//  - Clock clk; reset rst_n asynchronous, active-low. Reset: last_gnt=1 (r0 wins first tie),
//    r0_rvalid=r1_rvalid=b_rvalid=0, all rdata=0 via gating. RAM contents not cleared.
//  - Grant: only r0_req -> r0; only r1_req -> r1; both -> requester != last_gnt. At most one gnt.
//    last_gnt updates on every grant, holds otherwise. Grant is same-cycle, no bubble.
//  - Port A mux: granted requester's we/addr/wdata drive ram_d; no grant -> we=0.
//  - en = r0_req | r1_req | b_req; RAM held idle (no read, no write) when en=0.
//  - Read latency 1: rN_rvalid <= rN_gnt & ~rN_we; b_rvalid <= b_req. Valid lasts exactly one
//    cycle per access; back-to-back grants give back-to-back valids.
//  - Ungranted requester must keep req/we/addr/wdata stable; arbiter keeps no request queue.
//  - Port-B/port-A same-address collision (granted write to X, b_addr=X same cycle): RAM is
//    read-first -> b_rdata returns old contents (see CONFIGURATION).
//  - Port-A read same cycle as nothing else: normal. Port A write then read same addr next
//    cycle returns new data (no hazard on port A).
//  - rst_n asserted mid-access: pending valids dropped immediately, the in-flight RAM write
//    may or may not land; no rvalid after reset release until a new grant/b_req.
// CONFIGURATION
//  RAM_D_ARB_FWD_EN defined: on collision, register fwd_hit and wdata; next cycle b_rdata =
//    forwarded wdata instead of dob (write-first view for port B). fwd_hit reset 0.
//  Not defined: no forwarding logic; b_rdata = dob (old data on collision).
// STRUCTURE
//  - Package sgbm_ram_pkg: requester-id constants (REQ_R0=0, REQ_R1=1), default widths.
//  - One sub-module: ram_d (existing), instantiated with addr_bits/data_bits passed through.
//  - Arbitration, muxing, valid pipeline and forwarding inline in ram_d_arb.
// TESTING
//  1 reset then r0 write A=0x10 D=0x1234, r1 read A=0x10 next cycle -> r1_rvalid next, rdata=0x1234
//  2 r0,r1 both req reads continuously 6 cycles -> gnt r0,r1,r0,r1,r0,r1; valids alternate +1 cycle
//  3 only r1 req 3 cycles -> r1_gnt 3 consecutive cycles, r0_gnt=0; then tie -> r0 wins
//  4 mem[0x20]=0xAAAA; r0 write 0x20=0x5555 with b_req b_addr=0x20 -> b_rdata=0xAAAA (no macro),
//    0x5555 with RAM_D_ARB_FWD_EN; following b read -> 0x5555 both builds
//  5 rst_n low during granted read -> r0_rvalid=0 and r0_rdata=0 while low and cycle after release
//  6 all req low 4 cycles -> en=0, all valids 0, RAM contents unchanged (read back afterwards)

Source files
------------

// File: rtl/sgbm_ram_pkg.sv
// rtl/sgbm_ram_pkg.sv - shared constants for the line-store RAM arbiter
// Requester ids used for round-robin bookkeeping and default RAM geometry.
package sgbm_ram_pkg;

   localparam logic REQ_R0 = 1'b0;
   localparam logic REQ_R1 = 1'b1;

   localparam int DEF_ADDR_BITS = 8;
   localparam int DEF_DATA_BITS = 16;

endpackage

// File: rtl/ram_d.sv
// rtl/ram_d.sv - dual-port block RAM, port A read/write, port B read-only
// Ports:
//   clk          clock
//   en           common enable; no read and no write while low
//   wea          port A write enable
//   addra/addrb  port A / port B address
//   dia          port A write data
//   doa/dob      registered read data, 1-cycle latency, read-first
module ram_d
   import sgbm_ram_pkg::*;
#(
   parameter int addr_bits = DEF_ADDR_BITS,
   parameter int data_bits = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 wea,
   input  logic [addr_bits-1:0] addra,
   input  logic [addr_bits-1:0] addrb,
   input  logic [data_bits-1:0] dia,
   output logic [data_bits-1:0] doa,
   output logic [data_bits-1:0] dob
);

   logic [data_bits-1:0] mem [0:(1<<addr_bits)-1];

   // Read-first: both read ports see contents from before this cycle's write.
   always_ff @(posedge clk) begin
      if (en) begin
         if (wea) begin
            mem[addra] <= dia;
         end
         doa <= mem[addra];
         dob <= mem[addrb];
      end
   end

endmodule

// File: rtl/ram_d_arb.sv
// rtl/ram_d_arb.sv - round-robin port-A arbiter plus port-B reader around ram_d
// Optional feature macro: RAM_D_ARB_FWD_EN (write-first view on port B collisions).
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   rN_req/we/addr/wdata                port-A requester N access (N = 0, 1)
//   rN_gnt                              combinational grant, access this cycle
//   rN_rvalid/rN_rdata                  read return one cycle after a granted read
//   b_req/b_addr                        port-B read, never stalled
//   b_rvalid/b_rdata                    port-B return one cycle after b_req
module ram_d_arb
   import sgbm_ram_pkg::*;
#(
   parameter int addr_bits = DEF_ADDR_BITS,
   parameter int data_bits = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 r0_req,
   input  logic                 r0_we,
   input  logic [addr_bits-1:0] r0_addr,
   input  logic [data_bits-1:0] r0_wdata,
   output logic                 r0_gnt,
   output logic                 r0_rvalid,
   output logic [data_bits-1:0] r0_rdata,
   input  logic                 r1_req,
   input  logic                 r1_we,
   input  logic [addr_bits-1:0] r1_addr,
   input  logic [data_bits-1:0] r1_wdata,
   output logic                 r1_gnt,
   output logic                 r1_rvalid,
   output logic [data_bits-1:0] r1_rdata,
   input  logic                 b_req,
   input  logic [addr_bits-1:0] b_addr,
   output logic                 b_rvalid,
   output logic [data_bits-1:0] b_rdata
);

   logic                 last_gnt_q, last_gnt_d;
   logic                 r0_rvalid_q, r1_rvalid_q, b_rvalid_q;
   logic                 en;
   logic                 a_we;
   logic [addr_bits-1:0] a_addr;
   logic [data_bits-1:0] a_wdata;
   logic [data_bits-1:0] doa, dob;
   logic [data_bits-1:0] b_data;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      r0_gnt = r0_req & (~r1_req | (last_gnt_q == REQ_R1));
      r1_gnt = r1_req & ~r0_gnt;
      last_gnt_d = last_gnt_q;
      if (r0_gnt) begin
         last_gnt_d = REQ_R0;
      end else if (r1_gnt) begin
         last_gnt_d = REQ_R1;
      end
   end

   always_comb begin
      a_we    = 1'b0;
      a_addr  = r0_addr;
      a_wdata = r0_wdata;
      if (r1_gnt) begin
         a_we    = r1_we;
         a_addr  = r1_addr;
         a_wdata = r1_wdata;
      end else if (r0_gnt) begin
         a_we    = r0_we;
      end
   end

   assign en = r0_req | r1_req | b_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q  <= REQ_R1;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         b_rvalid_q  <= 1'b0;
      end else begin
         last_gnt_q  <= last_gnt_d;
         r0_rvalid_q <= r0_gnt & ~r0_we;
         r1_rvalid_q <= r1_gnt & ~r1_we;
         b_rvalid_q  <= b_req;
      end
   end

   ram_d #(
      .addr_bits(addr_bits),
      .data_bits(data_bits)
   ) u_ram (
      .clk  (clk),
      .en   (en),
      .wea  (a_we),
      .addra(a_addr),
      .addrb(b_addr),
      .dia  (a_wdata),
      .doa  (doa),
      .dob  (dob)
   );

`ifdef RAM_D_ARB_FWD_EN
   logic                 fwd_hit_q;
   logic [data_bits-1:0] fwd_data_q;

   // A port-A write to the address port B is reading this cycle: hand the
   // new word to port B next cycle instead of the RAM's read-first output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_hit_q  <= b_req & a_we & (a_addr == b_addr);
         fwd_data_q <= a_wdata;
      end
   end

   assign b_data = fwd_hit_q ? fwd_data_q : dob;
`else
   assign b_data = dob;
`endif

   // RAM outputs are not reset; gating keeps rdata at 0 whenever not valid.
   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign r0_rdata  = r0_rvalid_q ? doa : '0;
   assign r1_rdata  = r1_rvalid_q ? doa : '0;
   assign b_rdata   = b_rvalid_q ? b_data : '0;

endmodule
